spi_burst_ctrl: RTL and testbench

Upstream sequencer for `spi_master`. The host pushes bytes into a TX FIFO and pulses a go strobe. The block then feeds the bytes one at a time to `spi_master` over its start/done handshake and collects each received byte into an RX FIFO for the host to read. It turns the single-byte master into a multi-byte burst engine with flow control in both directions.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/spi_burst_ctrl.sv | 143 ++++++++++++++
 tb/tb_spi_burst_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI burst sequencer and spi_master.
// Pure declarations; no logic, no latency, no flow control.
package spi_pkg;

    localparam int SPI_BYTE_W     = 8;
    localparam int SPI_DEPTH      = 8;
    localparam int SPI_GAP_CYCLES = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_GAP
    } spi_state_t;

    // Gap counter holds GAP-1 at most, so it needs clog2(GAP) bits (never zero).
    function automatic int gap_cnt_w(input int gap);
        return (gap > 1) ? $clog2(gap) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO; head visible the cycle after the write, zero-latency pop.
// Writes when full and reads when empty are dropped; the caller flags them.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign wr_ok  = wr_vld && !full;
    assign rd_ok  = rd_vld && !empty;
    // Storage is not reset, so the head reads as zero whenever nothing is queued.
    assign rd_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Feeds TX FIFO bytes to spi_master one at a time and queues replies in an RX FIFO; go-to-start 2 cycles.
// Stalls before each byte while the RX FIFO is full; next start GAP_CYCLES+2 cycles after done.
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int DEPTH      = SPI_DEPTH,
    parameter int GAP_CYCLES = SPI_GAP_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_wr_en,
    input  logic [SPI_BYTE_W-1:0]   i_wr_data,
    output logic                    o_tx_full,
    input  logic                    i_go,
    output logic                    o_busy,
    input  logic                    i_rd_en,
    output logic [SPI_BYTE_W-1:0]   o_rd_data,
    output logic                    o_rx_empty,
    output logic [$clog2(DEPTH):0]  o_rx_count,
    output logic                    o_err,
    output logic                    o_spi_start,
    output logic [SPI_BYTE_W-1:0]   o_spi_tx_byte,
    input  logic                    i_spi_done,
    input  logic [SPI_BYTE_W-1:0]   i_spi_rx_byte
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = gap_cnt_w(GAP_CYCLES);

    spi_state_t            state;
    logic [GW-1:0]         gap_cnt;
    logic [SPI_BYTE_W-1:0] tx_head;
    logic [CW-1:0]         tx_count;
    logic                  tx_empty;
    logic                  rx_full;
    logic                  load_ok;
    logic                  tx_pop;
    logic                  rx_push;

    // A byte may only leave the TX FIFO once its reply is guaranteed a slot.
    assign load_ok = !rx_full && (tx_count != '0);
    assign tx_pop  = (state == S_LOAD) && load_ok;
    assign rx_push = (state == S_WAIT) && i_spi_done;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SPI_BYTE_W)
    ) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (i_wr_en),
        .wr_dat (i_wr_data),
        .rd_vld (tx_pop),
        .rd_dat (tx_head),
        .count  (tx_count),
        .full   (o_tx_full),
        .empty  (tx_empty)
    );

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SPI_BYTE_W)
    ) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (rx_push),
        .wr_dat (i_spi_rx_byte),
        .rd_vld (i_rd_en),
        .rd_dat (o_rd_data),
        .count  (o_rx_count),
        .full   (rx_full),
        .empty  (o_rx_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_err <= 1'b0;
        end else if ((i_wr_en && o_tx_full) || (i_rd_en && o_rx_empty)) begin
            o_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            o_busy        <= 1'b0;
            o_spi_start   <= 1'b0;
            o_spi_tx_byte <= '0;
            gap_cnt       <= '0;
        end else begin
            o_spi_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_go && !tx_empty) begin
                        state  <= S_LOAD;
                        o_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_ok) begin
                        o_spi_tx_byte <= tx_head;
                        o_spi_start   <= 1'b1;
                        state         <= S_START;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_spi_done) begin
                        if (GAP_CYCLES > 0) begin
                            state   <= S_GAP;
                            gap_cnt <= GW'(GAP_CYCLES - 1);
                        end else if (!tx_empty) begin
                            state <= S_LOAD;
                        end else begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    // Late TX writes are picked up here, extending the same burst.
                    if (gap_cnt == '0) begin
                        if (!tx_empty) begin
                            state <= S_LOAD;
                        end else begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl with a loopback spi_master responder of random latency.
// Expected bytes and timings come from queue-based bookkeeping of the documented rules.
module tb_spi_burst_ctrl;
    import spi_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_wr_en = 1'b0;
    logic [7:0]    i_wr_data = '0;
    logic          o_tx_full;
    logic          i_go = 1'b0;
    logic          o_busy;
    logic          i_rd_en = 1'b0;
    logic [7:0]    o_rd_data;
    logic          o_rx_empty;
    logic [CW-1:0] o_rx_count;
    logic          o_err;
    logic          o_spi_start;
    logic [7:0]    o_spi_tx_byte;
    logic          i_spi_done;
    logic [7:0]    i_spi_rx_byte;

    spi_burst_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_wr_en       (i_wr_en),
        .i_wr_data     (i_wr_data),
        .o_tx_full     (o_tx_full),
        .i_go          (i_go),
        .o_busy        (o_busy),
        .i_rd_en       (i_rd_en),
        .o_rd_data     (o_rd_data),
        .o_rx_empty    (o_rx_empty),
        .o_rx_count    (o_rx_count),
        .o_err         (o_err),
        .o_spi_start   (o_spi_start),
        .o_spi_tx_byte (o_spi_tx_byte),
        .i_spi_done    (i_spi_done),
        .i_spi_rx_byte (i_spi_rx_byte)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log, append-only; tests work from offsets taken at their start.
    int         start_cyc[$];
    logic [7:0] start_byte[$];
    int         done_cyc[$];
    int         busy_fall_cyc = 0;
    bit         prev_start = 0;
    bit         prev_busy = 0;
    bit         double_start = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_start = 0;
            prev_busy  = 0;
        end else begin
            if (o_spi_start) begin
                if (prev_start) double_start = 1;
                start_cyc.push_back(cyc);
                start_byte.push_back(o_spi_tx_byte);
            end
            if (i_spi_done) done_cyc.push_back(cyc);
            if (prev_busy && !o_busy) busy_fall_cyc = cyc;
            prev_start = o_spi_start;
            prev_busy  = o_busy;
        end
    end

    int stray_req = 0;

    initial begin : responder
        logic [7:0] b;
        int lat;
        bit abort;
        int stray_served;
        stray_served = 0;
        i_spi_done = 1'b0;
        i_spi_rx_byte = '0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_served) begin
                stray_served++;
                @(posedge clk); #1;
                i_spi_done = 1'b1; i_spi_rx_byte = 8'hEE;
                @(posedge clk); #1;
                i_spi_done = 1'b0; i_spi_rx_byte = '0;
            end else if (o_spi_start && !reset) begin
                b = o_spi_tx_byte;
                lat = $urandom_range(1, 4);
                abort = 0;
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk);
                    if (reset) abort = 1;
                end
                #1;
                if (!abort && !reset) begin
                    i_spi_done = 1'b1; i_spi_rx_byte = b;
                    @(posedge clk); #1;
                    i_spi_done = 1'b0; i_spi_rx_byte = '0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [7:0] b);
        i_wr_en = 1'b1; i_wr_data = b;
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic rd(output logic [7:0] d);
        d = o_rd_data;
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic go(output int gcyc);
        i_go = 1'b1; gcyc = cyc;
        tick();
        i_go = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!o_busy) begin ok = 1; break; end
            tick();
        end
    endtask

    task automatic wait_starts(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (start_cyc.size() >= n) begin ok = 1; break; end
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; i_wr_en = 0; i_rd_en = 0; i_go = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_checks++; if (o_spi_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", o_spi_start); end
        n_checks++; if (o_spi_tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h want 00", o_spi_tx_byte); end
        n_checks++; if (o_tx_full !== 1'b0) begin n_fail++; $display("FAIL reset_tx_full: got %b want 0", o_tx_full); end
        n_checks++; if (o_rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rx_empty: got %b want 1", o_rx_empty); end
        n_checks++; if (o_rx_count !== '0) begin n_fail++; $display("FAIL reset_rx_count: got %0d want 0", o_rx_count); end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", o_err); end
        n_checks++; if (o_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", o_rd_data); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_burst();
        logic [7:0] exp_b[3];
        logic [7:0] d;
        int sb, db, gcyc;
        bit ok;
        exp_b[0] = 8'hA5; exp_b[1] = 8'hF0; exp_b[2] = 8'h3C;
        do_reset();
        for (int i = 0; i < 3; i++) push(exp_b[i]);
        sb = start_cyc.size(); db = done_cyc.size();
        go(gcyc);
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b want 1", o_busy); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_idle_timeout: busy still %b want 0", o_busy); end
        tick();
        n_checks++; if (start_cyc.size() - sb !== 3) begin n_fail++; $display("FAIL basic_start_count: got %0d want 3", start_cyc.size() - sb); end
        if (start_cyc.size() - sb == 3 && done_cyc.size() - db == 3) begin
            n_checks++; if (start_cyc[sb] - gcyc !== 2) begin n_fail++; $display("FAIL basic_go_latency: got %0d want 2", start_cyc[sb] - gcyc); end
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (start_byte[sb+i] !== exp_b[i]) begin n_fail++; $display("FAIL basic_tx_byte%0d: got %h want %h", i, start_byte[sb+i], exp_b[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                n_checks++; if (start_cyc[sb+i] - done_cyc[db+i-1] !== GAP + 2) begin n_fail++; $display("FAIL basic_spacing%0d: got %0d want %0d", i, start_cyc[sb+i] - done_cyc[db+i-1], GAP + 2); end
            end
            n_checks++; if (busy_fall_cyc - done_cyc[db+2] !== GAP + 1) begin n_fail++; $display("FAIL basic_busy_fall: got %0d want %0d", busy_fall_cyc - done_cyc[db+2], GAP + 1); end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (o_rx_count !== CW'(3 - i)) begin n_fail++; $display("FAIL basic_rx_count%0d: got %0d want %0d", i, o_rx_count, 3 - i); end
            rd(d);
            n_checks++; if (d !== exp_b[i]) begin n_fail++; $display("FAIL basic_rx_byte%0d: got %h want %h", i, d, exp_b[i]); end
        end
        n_checks++; if (o_rx_empty !== 1'b1) begin n_fail++; $display("FAIL basic_rx_drained: got %b want 1", o_rx_empty); end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", o_err); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] d;
        int sb, gcyc;
        bit ok;
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            push(8'(i));
            if (i == DEPTH - 2) begin
                n_checks++; if (o_tx_full !== 1'b0) begin n_fail++; $display("FAIL ovf_not_full: got %b want 0", o_tx_full); end
            end
            if (i == DEPTH - 1) begin
                n_checks++; if (o_tx_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", o_tx_full); end
                n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_early: got %b want 0", o_err); end
            end
        end
        n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", o_err); end
        sb = start_cyc.size();
        go(gcyc);
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_idle_timeout: busy %b want 0", o_busy); end
        n_checks++; if (start_cyc.size() - sb !== DEPTH) begin n_fail++; $display("FAIL ovf_start_count: got %0d want %0d", start_cyc.size() - sb, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            rd(d);
            n_checks++; if (d !== 8'(i)) begin n_fail++; $display("FAIL ovf_rx_byte%0d: got %h want %h", i, d, 8'(i)); end
        end
        n_checks++; if (o_rx_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_extra_byte: rx_empty %b want 1", o_rx_empty); end
    endtask

    task automatic test_rx_backpressure();
        logic [7:0] exp_q[$];
        logic [7:0] b, d;
        int sb, gcyc;
        bit ok;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom); exp_q.push_back(b); push(b);
        end
        sb = start_cyc.size();
        go(gcyc);
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 100 && o_tx_full; w++) tick();
            b = 8'($urandom); exp_q.push_back(b); push(b);
        end
        wait_starts(sb + DEPTH, ok);
        repeat (40) tick();
        n_checks++; if (start_cyc.size() - sb !== DEPTH) begin n_fail++; $display("FAIL bp_stall_starts: got %0d want %0d", start_cyc.size() - sb, DEPTH); end
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL bp_stall_busy: got %b want 1", o_busy); end
        n_checks++; if (o_rx_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL bp_stall_count: got %0d want %0d", o_rx_count, DEPTH); end
        for (int k = 1; k <= 2; k++) begin
            rd(d);
            n_checks++; if (d !== exp_q[0]) begin n_fail++; $display("FAIL bp_read%0d: got %h want %h", k, d, exp_q[0]); end
            void'(exp_q.pop_front());
            wait_starts(sb + DEPTH + k, ok);
            repeat (40) tick();
            n_checks++; if (start_cyc.size() - sb !== DEPTH + k) begin n_fail++; $display("FAIL bp_resume%0d_starts: got %0d want %0d", k, start_cyc.size() - sb, DEPTH + k); end
            n_checks++; if (o_rx_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL bp_resume%0d_count: got %0d want %0d", k, o_rx_count, DEPTH); end
        end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_idle_timeout: busy %b want 0", o_busy); end
        while (exp_q.size() > 0) begin
            rd(d);
            n_checks++; if (d !== exp_q[0]) begin n_fail++; $display("FAIL bp_drain: got %h want %h", d, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL bp_err: got %b want 0", o_err); end
    endtask

    task automatic test_empty_ops();
        int sb, gcyc, busy_seen;
        do_reset();
        sb = start_cyc.size();
        busy_seen = 0;
        go(gcyc);
        for (int i = 0; i < 10; i++) begin
            if (o_busy) busy_seen++;
            tick();
        end
        n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL empty_go_busy: busy for %0d cycles want 0", busy_seen); end
        n_checks++; if (start_cyc.size() - sb !== 0) begin n_fail++; $display("FAIL empty_go_start: got %0d starts want 0", start_cyc.size() - sb); end
        stray_req++;
        repeat (5) tick();
        n_checks++; if (o_rx_count !== '0) begin n_fail++; $display("FAIL stray_done_count: got %0d want 0", o_rx_count); end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL empty_err_early: got %b want 0", o_err); end
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
        n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL empty_read_err: got %b want 1", o_err); end
        n_checks++; if (o_rx_count !== '0) begin n_fail++; $display("FAIL empty_read_count: got %0d want 0", o_rx_count); end
        n_checks++; if (o_rx_empty !== 1'b1) begin n_fail++; $display("FAIL empty_read_empty: got %b want 1", o_rx_empty); end
    endtask

    task automatic test_mid_burst_append();
        logic [7:0] d;
        int sb, gcyc;
        bit ok;
        do_reset();
        push(8'h11);
        sb = start_cyc.size();
        go(gcyc);
        wait_starts(sb + 1, ok);
        push(8'h22);
        wait_idle(ok);
        n_checks++; if (start_cyc.size() - sb !== 2) begin n_fail++; $display("FAIL append_starts: got %0d want 2", start_cyc.size() - sb); end
        if (start_cyc.size() - sb == 2) begin
            n_checks++; if (start_byte[sb+1] !== 8'h22) begin n_fail++; $display("FAIL append_tx_byte: got %h want 22", start_byte[sb+1]); end
        end
        rd(d);
        n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL append_rx0: got %h want 11", d); end
        rd(d);
        n_checks++; if (d !== 8'h22) begin n_fail++; $display("FAIL append_rx1: got %h want 22", d); end
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] d;
        int sb, gcyc;
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) push(8'($urandom));
        sb = start_cyc.size();
        go(gcyc);
        wait_starts(sb + 2, ok);
        #1 reset = 1'b1;
        #1;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
        n_checks++; if (o_rx_count !== '0 || o_rx_empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_rx: count %0d empty %b want 0 1", o_rx_count, o_rx_empty); end
        n_checks++; if (o_spi_tx_byte !== 8'h00 || o_rd_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: tx %h rd %h want 00 00", o_spi_tx_byte, o_rd_data); end
        repeat (3) tick();
        reset = 1'b0;
        sb = start_cyc.size();
        repeat (20) tick();
        n_checks++; if (start_cyc.size() - sb !== 0) begin n_fail++; $display("FAIL rstmid_late_start: got %0d want 0", start_cyc.size() - sb); end
        push(8'hC3);
        go(gcyc);
        wait_idle(ok);
        n_checks++; if (start_cyc.size() - sb !== 1) begin n_fail++; $display("FAIL rstmid_fresh_starts: got %0d want 1", start_cyc.size() - sb); end
        rd(d);
        n_checks++; if (d !== 8'hC3) begin n_fail++; $display("FAIL rstmid_fresh_rx: got %h want c3", d); end
    endtask

    task automatic test_random_bursts();
        logic [7:0] exp_q[$];
        logic [7:0] b, d;
        int sb, db, gcyc, n;
        bit ok;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom); exp_q.push_back(b); push(b);
            end
            sb = start_cyc.size(); db = done_cyc.size();
            go(gcyc);
            wait_idle(ok);
            tick();
            n_checks++; if (start_cyc.size() - sb !== n) begin n_fail++; $display("FAIL rand%0d_starts: got %0d want %0d", r, start_cyc.size() - sb, n); end
            if (start_cyc.size() - sb == n && done_cyc.size() - db == n) begin
                for (int i = 0; i < n; i++) begin
                    n_checks++; if (start_byte[sb+i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_tx%0d: got %h want %h", r, i, start_byte[sb+i], exp_q[i]); end
                    if (i > 0) begin
                        n_checks++; if (start_cyc[sb+i] - done_cyc[db+i-1] !== GAP + 2) begin n_fail++; $display("FAIL rand%0d_spacing%0d: got %0d want %0d", r, i, start_cyc[sb+i] - done_cyc[db+i-1], GAP + 2); end
                    end
                end
                n_checks++; if (busy_fall_cyc - done_cyc[db+n-1] !== GAP + 1) begin n_fail++; $display("FAIL rand%0d_busy_fall: got %0d want %0d", r, busy_fall_cyc - done_cyc[db+n-1], GAP + 1); end
            end
            while (exp_q.size() > 0) begin
                n_checks++; if (o_rx_count !== CW'(exp_q.size())) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", r, o_rx_count, exp_q.size()); end
                rd(d);
                n_checks++; if (d !== exp_q[0]) begin n_fail++; $display("FAIL rand%0d_rx: got %h want %h", r, d, exp_q[0]); end
                void'(exp_q.pop_front());
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        n_checks++; if (double_start !== 1'b0) begin n_fail++; $display("FAIL double_start: got %b want 0", double_start); end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL rand_err: got %b want 0", o_err); end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_tx_overflow();
        test_rx_backpressure();
        test_empty_ops();
        test_mid_burst_append();
        test_reset_mid_transfer();
        test_random_bursts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
